// File: rtl/axis_arbiter_wrr_if.sv
// axis_arbiter_wrr_if: request/grant bundle between requesters and the
// weighted round-robin arbiter.
//   request, acknowledge  per-port request and end-of-transaction strobe
//   weight                packed per-port weights, port p at [p*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   grant, grant_valid    registered one-hot grant and its OR
//   grant_encoded         index of the granted port, 0 when idle
//   credit_remaining      transactions left for the last-granted port
// master = requester side, slave = arbiter side.
interface axis_arbiter_wrr_if #(
  parameter int PORTS        = 4,
  parameter int WEIGHT_WIDTH = 4
);
  localparam int CL_PORTS = $clog2(PORTS);

  logic [PORTS-1:0]              request;
  logic [PORTS-1:0]              acknowledge;
  logic [PORTS*WEIGHT_WIDTH-1:0] weight;
  logic [PORTS-1:0]              grant;
  logic                          grant_valid;
  logic [CL_PORTS-1:0]           grant_encoded;
  logic [WEIGHT_WIDTH-1:0]       credit_remaining;

  modport master (
    output request, acknowledge, weight,
    input  grant, grant_valid, grant_encoded, credit_remaining
  );

  modport slave (
    input  request, acknowledge, weight,
    output grant, grant_valid, grant_encoded, credit_remaining
  );
endinterface

// File: rtl/axis_arbiter_wrr_priority_encoder.sv
// axis_arbiter_wrr_priority_encoder: picks one set bit of in_req.
//   in_req     request vector
//   out_valid  any bit set
//   out_index  lowest set bit when LSB_HIGH_PRIORITY=1, highest otherwise; 0 when none
module axis_arbiter_wrr_priority_encoder #(
  parameter int WIDTH             = 4,
  parameter bit LSB_HIGH_PRIORITY = 1'b1
) (
  input  logic [WIDTH-1:0]         in_req,
  output logic                     out_valid,
  output logic [$clog2(WIDTH)-1:0] out_index
);
  localparam int CL = $clog2(WIDTH);

  always_comb begin
    out_valid = |in_req;
    out_index = '0;
    if (LSB_HIGH_PRIORITY) begin
      // Descending walk: the last hit written is the lowest set bit.
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (in_req[i]) out_index = CL'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_req[i]) out_index = CL'(i);
      end
    end
  end
endmodule

// File: rtl/axis_arbiter_wrr.sv
// axis_arbiter_wrr: weighted round-robin arbiter. A granted port may run up
// to weight[p] back-to-back transactions before priority rotates.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   arb    slave side of axis_arbiter_wrr_if (request/acknowledge/weight in,
//          grant/grant_valid/grant_encoded/credit_remaining out, all registered)
module axis_arbiter_wrr #(
  parameter int PORTS                 = 4,
  parameter int WEIGHT_WIDTH          = 4,
  parameter bit ARB_BLOCK_ACK         = 1'b1,
  parameter bit ARB_LSB_HIGH_PRIORITY = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  axis_arbiter_wrr_if.slave arb
);
  localparam int CL_PORTS = $clog2(PORTS);
  localparam logic [CL_PORTS-1:0] LAST_RESET =
    ARB_LSB_HIGH_PRIORITY ? CL_PORTS'(PORTS - 1) : '0;

  logic [PORTS-1:0]        grant_q, grant_d;
  logic                    valid_q, valid_d;
  logic [CL_PORTS-1:0]     enc_q, enc_d;
  logic [CL_PORTS-1:0]     last_q, last_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

  logic                    release_evt;
  logic                    hold;
  logic [WEIGHT_WIDTH-1:0] credit_dec;
  logic [PORTS-1:0]        masked_req;
  logic                    masked_valid, full_valid;
  logic [CL_PORTS-1:0]     masked_idx, full_idx, pick;
  logic [WEIGHT_WIDTH-1:0] pick_weight;

  // Rotated window: ports strictly after last in scan order. The unmasked
  // encoder covers the wrap-around, including last itself as lowest priority.
  always_comb begin
    masked_req = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (ARB_LSB_HIGH_PRIORITY)
        masked_req[i] = arb.request[i] && (i > int'(last_q));
      else
        masked_req[i] = arb.request[i] && (i < int'(last_q));
    end
  end

  axis_arbiter_wrr_priority_encoder #(
    .WIDTH            (PORTS),
    .LSB_HIGH_PRIORITY(ARB_LSB_HIGH_PRIORITY)
  ) u_pe_masked (
    .in_req   (masked_req),
    .out_valid(masked_valid),
    .out_index(masked_idx)
  );

  axis_arbiter_wrr_priority_encoder #(
    .WIDTH            (PORTS),
    .LSB_HIGH_PRIORITY(ARB_LSB_HIGH_PRIORITY)
  ) u_pe_full (
    .in_req   (arb.request),
    .out_valid(full_valid),
    .out_index(full_idx)
  );

  always_comb begin
    grant_d  = grant_q;
    valid_d  = valid_q;
    enc_d    = enc_q;
    last_d   = last_q;
    credit_d = credit_q;

    if (ARB_BLOCK_ACK)
      release_evt = valid_q && |(arb.acknowledge & grant_q);
    else
      release_evt = valid_q && !(|(arb.request & grant_q));
    hold = valid_q && !release_evt;

    credit_dec = (release_evt && credit_q != '0) ? credit_q - 1'b1 : credit_q;

    pick        = masked_valid ? masked_idx : full_idx;
    pick_weight = arb.weight[int'(pick)*WEIGHT_WIDTH +: WEIGHT_WIDTH];

    if (!hold) begin
      if (credit_dec != '0 && arb.request[last_q]) begin
        // Retained credit: stay on last with no bubble, no reload.
        grant_d  = {{(PORTS-1){1'b0}}, 1'b1} << last_q;
        valid_d  = 1'b1;
        enc_d    = last_q;
        credit_d = credit_dec;
      end else if (full_valid) begin
        grant_d  = {{(PORTS-1){1'b0}}, 1'b1} << pick;
        valid_d  = 1'b1;
        enc_d    = pick;
        last_d   = pick;
        credit_d = (pick_weight == '0) ? WEIGHT_WIDTH'(1) : pick_weight;
      end else begin
        grant_d  = '0;
        valid_d  = 1'b0;
        enc_d    = '0;
        credit_d = credit_dec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q  <= '0;
      valid_q  <= 1'b0;
      enc_q    <= '0;
      last_q   <= LAST_RESET;
      credit_q <= '0;
    end else begin
      grant_q  <= grant_d;
      valid_q  <= valid_d;
      enc_q    <= enc_d;
      last_q   <= last_d;
      credit_q <= credit_d;
    end
  end

  assign arb.grant            = grant_q;
  assign arb.grant_valid      = valid_q;
  assign arb.grant_encoded    = enc_q;
  assign arb.credit_remaining = credit_q;
endmodule

// File: tb/tb_axis_arbiter_wrr.sv
// Directed bench for axis_arbiter_wrr. Three instances:
//   a: ack mode, ascending scan
//   b: request-drop mode, ascending scan
//   c: ack mode, descending scan
module tb_axis_arbiter_wrr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  axis_arbiter_wrr_if #(.PORTS(4), .WEIGHT_WIDTH(4)) if_a ();
  axis_arbiter_wrr_if #(.PORTS(4), .WEIGHT_WIDTH(4)) if_b ();
  axis_arbiter_wrr_if #(.PORTS(4), .WEIGHT_WIDTH(4)) if_c ();

  axis_arbiter_wrr #(.PORTS(4), .WEIGHT_WIDTH(4), .ARB_BLOCK_ACK(1'b1),
                     .ARB_LSB_HIGH_PRIORITY(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .arb(if_a));
  axis_arbiter_wrr #(.PORTS(4), .WEIGHT_WIDTH(4), .ARB_BLOCK_ACK(1'b0),
                     .ARB_LSB_HIGH_PRIORITY(1'b1)) dut_b (.clk(clk), .rst_n(rst_n), .arb(if_b));
  axis_arbiter_wrr #(.PORTS(4), .WEIGHT_WIDTH(4), .ARB_BLOCK_ACK(1'b1),
                     .ARB_LSB_HIGH_PRIORITY(1'b0)) dut_c (.clk(clk), .rst_n(rst_n), .arb(if_c));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at edge+1; pulses reset within the cycle, returns at edge+3.
  task automatic do_reset();
    rst_n = 1'b0;
    if_a.request = '0; if_a.acknowledge = '0;
    if_b.request = '0; if_b.acknowledge = '0;
    if_c.request = '0; if_c.acknowledge = '0;
    #2;
    rst_n = 1'b1;
  endtask

  int exp_grant[8]  = '{0, 0, 0, 1, 0, 0, 0, 1};
  int exp_credit[8] = '{3, 2, 1, 1, 3, 2, 1, 1};

  initial begin
    if_a.request = 4'b1111; if_a.acknowledge = '0; if_a.weight = 16'h1111;
    if_b.request = '0;      if_b.acknowledge = '0; if_b.weight = 16'h1111;
    if_c.request = 4'b1111; if_c.acknowledge = '0; if_c.weight = 16'h1111;

    // Reset with requests pending: everything stays clear.
    step();
    check_val("rst_grant", 32'(if_a.grant), 0);
    check_val("rst_valid", 32'(if_a.grant_valid), 0);
    check_val("rst_enc", 32'(if_a.grant_encoded), 0);
    check_val("rst_credit", 32'(if_a.credit_remaining), 0);
    rst_n = 1'b1;

    // First arbitration follows the reset pointer.
    step();
    check_val("first_enc_a", 32'(if_a.grant_encoded), 0);
    check_val("first_valid_a", 32'(if_a.grant_valid), 1);
    check_val("first_credit_a", 32'(if_a.credit_remaining), 1);
    check_val("first_enc_c", 32'(if_c.grant_encoded), 3);
    if_c.acknowledge = if_c.grant;
    step();
    check_val("second_enc_c", 32'(if_c.grant_encoded), 2);

    // Weighted burst: port 0 weight 3, port 1 weight 1, ack every cycle.
    do_reset();
    if_a.weight  = 16'h1113;
    if_a.request = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      step();
      check_val($sformatf("burst_enc%0d", i), 32'(if_a.grant_encoded), 32'(exp_grant[i]));
      check_val($sformatf("burst_credit%0d", i), 32'(if_a.credit_remaining), 32'(exp_credit[i]));
      if_a.acknowledge = if_a.grant;
    end

    // Weight 0 behaves as 1; sole requester regranted with no gap.
    do_reset();
    if_a.weight  = 16'h1011;
    if_a.request = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val($sformatf("w0_grant%0d", i), 32'(if_a.grant), 32'h4);
      check_val($sformatf("w0_credit%0d", i), 32'(if_a.credit_remaining), 1);
      if_a.acknowledge = if_a.grant;
    end

    // Early yield: port 0 (weight 4) drops after two transactions.
    do_reset();
    if_a.weight  = 16'h1114;
    if_a.request = 4'b1001;
    step();
    check_val("yield_g1", 32'(if_a.grant), 32'h1);
    check_val("yield_c1", 32'(if_a.credit_remaining), 4);
    if_a.acknowledge = 4'b0001;
    step();
    check_val("yield_g2", 32'(if_a.grant), 32'h1);
    check_val("yield_c2", 32'(if_a.credit_remaining), 3);
    if_a.acknowledge = 4'b0001;
    if_a.request     = 4'b1000;
    step();
    check_val("yield_g3", 32'(if_a.grant), 32'h8);
    check_val("yield_c3", 32'(if_a.credit_remaining), 1);
    if_a.acknowledge = 4'b1000;
    if_a.request     = 4'b1001;
    step();
    check_val("yield_g4", 32'(if_a.grant), 32'h1);
    check_val("yield_c4", 32'(if_a.credit_remaining), 4);
    if_a.acknowledge = '0;

    // Request-drop mode: port 1 holds while requesting, then hands to port 2.
    do_reset();
    if_b.request = 4'b1110;
    step();
    check_val("drop_first", 32'(if_b.grant), 32'h2);
    for (int i = 0; i < 4; i++) begin
      step();
      check_val($sformatf("drop_hold%0d", i), 32'(if_b.grant), 32'h2);
    end
    if_b.request = 4'b1100;
    #1;
    check_val("drop_last_cycle", 32'(if_b.grant), 32'h2);
    step();
    check_val("drop_next", 32'(if_b.grant), 32'h4);

    // Async reset mid-grant clears outputs without a clock edge.
    do_reset();
    if_a.weight  = 16'h1111;
    if_a.request = 4'b0100;
    step();
    check_val("async_pre", 32'(if_a.grant), 32'h4);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("async_grant", 32'(if_a.grant), 0);
    check_val("async_valid", 32'(if_a.grant_valid), 0);
    check_val("async_credit", 32'(if_a.credit_remaining), 0);
    if_a.request = 4'b1111;
    rst_n = 1'b1;
    step();
    check_val("async_restart", 32'(if_a.grant), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_arbiter_wrr.md
# axis_arbiter_wrr

Weighted round-robin arbiter for PORTS requesters. Each granted port may complete up to weight[p] consecutive transactions before priority rotates to the next requester. Grants are registered and held until a transaction-end event: acknowledge, or request deassertion. It sits in front of AXI-Stream muxes and switch output ports that need bandwidth shares rather than plain fairness.

## Interface
- PORTS, 4: number of requesters, ≥2
- WEIGHT_WIDTH, 4: width of each per-port weight and of the credit counter
- ARB_BLOCK_ACK, 1: 1 = transaction ends on acknowledge[g]; 0 = transaction ends when request[g] deasserts
- ARB_LSB_HIGH_PRIORITY, 1: 1 = rotation scans ascending, first scan after reset starts at port 0; 0 = scans descending, first scan starts at port PORTS-1

- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  reset, asynchronous assert, active-low
- request  in  PORTS  per-port request
- acknowledge  in  PORTS  per-port end-of-transaction strobe; ignored when ARB_BLOCK_ACK=0
- weight  in  PORTS*WEIGHT_WIDTH  port p weight at [p*WEIGHT_WIDTH +: WEIGHT_WIDTH]; 0 is treated as 1
- grant  out  PORTS  one-hot grant, registered
- grant_valid  out  1  OR of grant
- grant_encoded  out  $clog2(PORTS)  index of granted port; 0 when idle
- credit_remaining  out  WEIGHT_WIDTH  transactions left for the last-granted port

## Operation
- State: grant register g, last-port pointer last, credit counter credit.
- Reset values: grant=0, grant_valid=0, grant_encoded=0, credit=0, credit_remaining=0. last=PORTS-1 when ARB_LSB_HIGH_PRIORITY=1; last=0 when it is 0. The first scan therefore begins at port 0 or port PORTS-1 respectively.
- Holding: grant_valid && !release.
  - release = acknowledge[g] when ARB_BLOCK_ACK=1.
  - release = !request[g] when ARB_BLOCK_ACK=0.
  - While holding, grant is unchanged and request/acknowledge of other ports are ignored.
- Not holding (idle, or release this cycle): arbitrate over the current request vector.
  - If credit != 0, port last has top priority when it is requesting.
  - Otherwise, and whenever port last is not requesting, scan from last±1 with wrap-around (direction set by ARB_LSB_HIGH_PRIORITY).
  - No request: grant goes to 0 next cycle.
- Credit accounting:
  - On release: credit ← credit−1, saturating at 0.
  - On a new grant to port p: if p==last and the post-release credit is nonzero, credit is kept; otherwise credit ← max(weight[p],1) and last ← p.
  - Release and new grant in the same cycle: apply the decrement first, then the grant rule.
- weight is sampled only at credit reload; weight changes mid-burst take effect at the next reload.
- acknowledge on a non-granted port, or while idle, is ignored.
- A port granted back-to-back by retained credit shows no grant gap.

## Timing
- Request to grant: request sampled in cycle N, grant visible in cycle N+1.
- Release in cycle N → new grant or idle in cycle N+1. Zero bubble cycles between transactions.
- grant, grant_valid, grant_encoded and credit_remaining are all registered and change together.
- Reset mid-burst: outputs clear asynchronously. The first arbitration after reset release follows the reset pointer.

## Structure
- Shared package: none needed. Mode encodings are parameters; derive the localparam CL_PORTS=$clog2(PORTS) locally.
- One sub-module: priority_encoder (WIDTH=PORTS, LSB_HIGH_PRIORITY passthrough). Instantiate it twice: once on request masked to the rotated window, once on the unmasked request as fallback. Same scheme as the existing round-robin arbiter.
- Implementation is 150–250 lines of RTL.

## Test plan
- Reset/idle: rst_n low, request=4'b1111 → all outputs 0. Release reset, ACK mode, weights all 1 → grant_encoded 0 in the cycle after reset release.
- Weighted burst: weight[0]=3, weight[1]=1, request=4'b0011 held, acknowledge pulsed on granted port every cycle → grant sequence 0,0,0,1,0,0,0,1. credit_remaining shows 3,2,1,1,3,…
- Weight 0: weight[2]=0, only port 2 requesting → port 2 granted once per ack, credit_remaining=1.
- Request-drop mode (ARB_BLOCK_ACK=0): port 1 requests 5 cycles, ports 2 and 3 waiting → grant stays on port 1 through the cycle after its request drops. Then port 2 is granted with no gap.
- Early yield: weight[0]=4, port 0 deasserts after 2 transactions while port 3 requests → port 3 granted next cycle. When port 0 re-requests later, credit reloads to 4.
- Async reset mid-burst: rst_n pulled low between clock edges while grant=4'b0100 → grant=0 immediately, without waiting for a clock edge. After release, arbitration restarts from the reset pointer.
